pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. Every cycle it drives the stall and bubble inputs of the F, D, E, M and W pipeline registers. It resolves load/use hazards, `ret` hazards and mispredicted branches, and freezes the pipe while instruction or data memory is not ready. It also parks the core permanently once an exception status reaches write-back. It sits beside the datapath, takes stage-register fields and memory handshake signals as inputs, and exposes a small status/performance interface.

---
 rtl/pipe_ctrl.sv | 68 ++++++
 tb/tb_pipe_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble control for the five-stage Y86-64 pipeline with memory-wait and halt FSM
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic             e_Cnd_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_bubble_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALTED = 2'd2} state_t;
  state_t state, state_nx;
  logic lu, rt, mp, iw, exc, halt, wt, ex, hz;
  logic [8:0] ctl;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= RUN;
    else state <= state_nx;
  always_comb begin
    lu = (E_icode_i == 4'h5 || E_icode_i == 4'hB) && E_dstM_i != 4'hF &&
         (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    rt = D_icode_i == 4'h9 || E_icode_i == 4'h9 || M_icode_i == 4'h9;
    mp = E_icode_i == 4'h7 && !e_Cnd_i;
    iw = !imem_ready_i;
    exc = W_stat_i != 3'd1;
    halt = state == HALTED;
    wt = state == MEM_WAIT ? !dmem_ready_i : state == RUN && !exc && dmem_req_i && !dmem_ready_i;
    ex = !halt && !wt && exc;
    hz = !halt && !wt && !exc;
    ctl = {halt | wt | ex | (hz & (lu | rt | iw)),
           halt | wt | ex | (hz & lu),
           halt | wt | ex,
           halt | wt,
           halt | ex,
           hz & !lu & (mp | rt | iw),
           hz & (mp | lu),
           ex | (hz & m_stat_i != 3'd1),
           wt};
    state_nx = (halt || ex) ? HALTED : wt ? MEM_WAIT : RUN;
  end
  assign {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
          D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o} = rst_n_i ? ctl : 9'd0;
  assign state_o = state;
  assign halted_o = state == HALTED;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) stall_cnt_o <= '0;
    else if (F_stall_o && state != HALTED && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a rule-level reference model
module tb_pipe_ctrl;
  localparam int W = 4;
  logic clk_i = 0, rst_n_i = 0;
  logic [3:0] D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i;
  logic e_Cnd_i, imem_ready_i, dmem_req_i, dmem_ready_i;
  logic [2:0] m_stat_i, W_stat_i;
  logic F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
  logic D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o, halted_o;
  logic [1:0] state_o;
  logic [W-1:0] stall_cnt_o;
  pipe_ctrl #(.CNT_W(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .D_icode_i(D_icode_i), .E_icode_i(E_icode_i), .M_icode_i(M_icode_i),
    .E_dstM_i(E_dstM_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .e_Cnd_i(e_Cnd_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
    .imem_ready_i(imem_ready_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
    .M_stall_o(M_stall_o), .W_stall_o(W_stall_o),
    .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o),
    .W_bubble_o(W_bubble_o), .state_o(state_o), .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  wire [8:0] dut_out = {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
                        D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o};
  int checks = 0, errors = 0, m_st = 0, m_cnt = 0;
  logic [8:0] m_out;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [8:0] ref_out(input int st);
    logic lu, rt, mp, iw;
    if (st == 2) return 9'b11111_0000;
    if (st == 1 && !dmem_ready_i) return 9'b11110_0001;
    if (W_stat_i != 3'd1) return 9'b11101_0010;
    if (st == 0 && dmem_req_i && !dmem_ready_i) return 9'b11110_0001;
    lu = (E_icode_i == 5 || E_icode_i == 11) && E_dstM_i != 15 &&
         (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    rt = D_icode_i == 9 || E_icode_i == 9 || M_icode_i == 9;
    mp = E_icode_i == 7 && !e_Cnd_i;
    iw = !imem_ready_i;
    return {lu | rt | iw, lu, 3'b000, !lu & (mp | rt | iw), mp | lu, m_stat_i != 3'd1, 1'b0};
  endfunction
  function automatic int ref_next(input int st);
    if (st == 2) return 2;
    if (st == 1) return !dmem_ready_i ? 1 : (W_stat_i != 3'd1 ? 2 : 0);
    if (W_stat_i != 3'd1) return 2;
    return (dmem_req_i && !dmem_ready_i) ? 1 : 0;
  endfunction
  task automatic cycle();
    #2;
    m_out = ref_out(m_st);
    chk("outs", 32'(dut_out), 32'(m_out));
    chk("state", 32'(state_o), m_st);
    chk("halted", 32'(halted_o), 32'(m_st == 2));
    chk("cnt", 32'(stall_cnt_o), m_cnt);
    @(posedge clk_i);
    if (m_out[8] && m_st != 2 && m_cnt < (1 << W) - 1) m_cnt++;
    m_st = ref_next(m_st);
    @(negedge clk_i);
  endtask
  task automatic rst_pulse();
    rst_n_i = 0;
    #2;
    chk("rst_outs", 32'(dut_out), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_cnt", 32'(stall_cnt_o), 0);
    m_st = 0;
    m_cnt = 0;
    @(negedge clk_i);
    rst_n_i = 1;
  endtask
  task automatic idle();
    D_icode_i = 1; E_icode_i = 1; M_icode_i = 1;
    E_dstM_i = 15; d_srcA_i = 15; d_srcB_i = 15;
    e_Cnd_i = 1; m_stat_i = 1; W_stat_i = 1;
    imem_ready_i = 1; dmem_req_i = 0; dmem_ready_i = 1;
  endtask
  task automatic rnd(input int exc_rate);
    logic [3:0] pick [8] = '{4'h1, 4'h5, 4'h7, 4'h9, 4'hB, 4'h8, 4'h2, 4'h6};
    D_icode_i = pick[$urandom_range(0, 7)];
    E_icode_i = pick[$urandom_range(0, 7)];
    M_icode_i = pick[$urandom_range(0, 7)];
    E_dstM_i = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    d_srcA_i = 4'($urandom_range(0, 5));
    d_srcB_i = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    e_Cnd_i = 1'($urandom_range(0, 1));
    m_stat_i = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    W_stat_i = ($urandom_range(0, exc_rate) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    imem_ready_i = $urandom_range(0, 4) != 0;
    dmem_req_i = $urandom_range(0, 2) == 0;
    dmem_ready_i = $urandom_range(0, 4) > 1;
  endtask
  initial begin
    idle();
    @(negedge clk_i);
    rst_pulse();
    cycle();
    E_icode_i = 5; E_dstM_i = 3; d_srcA_i = 3;
    cycle();
    idle();
    cycle();
    E_icode_i = 7; e_Cnd_i = 0;
    cycle();
    idle(); D_icode_i = 9;
    cycle();
    idle(); E_icode_i = 9;
    cycle();
    idle(); M_icode_i = 9;
    cycle();
    idle(); D_icode_i = 9; E_icode_i = 5; E_dstM_i = 3; d_srcA_i = 3;
    cycle();
    idle(); dmem_req_i = 1; dmem_ready_i = 0;
    repeat (3) cycle();
    dmem_ready_i = 1;
    cycle();
    idle();
    cycle();
    dmem_req_i = 1; dmem_ready_i = 0;
    repeat (2) cycle();
    rst_pulse();
    idle();
    cycle();
    W_stat_i = 3;
    cycle();
    for (int i = 0; i < 20; i++) begin
      rnd(1);
      cycle();
    end
    rst_pulse();
    idle(); imem_ready_i = 0;
    repeat (20) cycle();
    for (int i = 0; i < 3000; i++) begin
      rnd(200);
      cycle();
      if (i % 120 == 119) rst_pulse();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
